// File: rtl/sdram_cmd_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller command FIFO between NUM_REQ
// requesters, with an owner-tag FIFO that routes read data back to its requester.
module sdram_cmd_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int MAX_BURST = 8,
    parameter int TAG_DEPTH = 8
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ-1:0]      req_wr_n,
    input  logic [NUM_REQ*25-1:0]   req_addr,
    input  logic [NUM_REQ*2-1:0]    req_be_n,
    input  logic [NUM_REQ*16-1:0]   req_data,
    output logic                    efifo_wr,
    output logic [43:0]             efifo_wr_data,
    input  logic                    efifo_full,
    input  logic                    rsp_valid,
    input  logic [15:0]             rsp_data,
    output logic [NUM_REQ-1:0]      rd_valid,
    output logic [15:0]             rd_data,
    output logic                    tag_err
);

    localparam int GW = $clog2(NUM_REQ);
    localparam int TW = $clog2(TAG_DEPTH);
    localparam int CW = TW + 1;
    localparam logic [7:0]    BURST_LAST   = 8'(MAX_BURST);
    localparam logic [CW-1:0] TAG_FULL_CNT = CW'(TAG_DEPTH);

    typedef enum logic {IDLE, GRANT} state_e;

    state_e              state_q, state_d;
    logic [GW-1:0]       grant_q, grant_d;
    logic [GW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [7:0]          beat_q, beat_d;
    logic [GW-1:0]       tag_mem_q [TAG_DEPTH];
    logic [TW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [TW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                tag_err_q, tag_err_d;
    logic [NUM_REQ-1:0]  rd_valid_q, rd_valid_d;
    logic [15:0]         rd_data_q, rd_data_d;

    logic        g_valid, g_rd, tag_full, accept, push, pop, found;
    logic [43:0] g_word;
    int          idx;

    // Mux out the granted requester's command fields.
    always_comb begin
        g_valid = 1'b0;
        g_rd    = 1'b0;
        g_word  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == GW'(i)) begin
                g_valid = req_valid[i];
                g_rd    = req_wr_n[i];
                g_word  = {req_wr_n[i], req_addr[25*i +: 25], req_be_n[2*i +: 2], req_data[16*i +: 16]};
            end
        end
    end

    assign tag_full = (cnt_q == TAG_FULL_CNT);
    assign accept   = (state_q == GRANT) && g_valid && !efifo_full && !(g_rd && tag_full);
    assign push     = accept && g_rd;
    assign pop      = rsp_valid && (cnt_q != '0);

    assign req_ready     = accept ? (NUM_REQ'(1) << grant_q) : '0;
    assign efifo_wr      = accept;
    assign efifo_wr_data = accept ? g_word : '0;
    assign rd_valid      = rd_valid_q;
    assign rd_data       = rd_data_q;
    assign tag_err       = tag_err_q;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        beat_d   = beat_q;
        found    = 1'b0;
        idx      = 0;
        case (state_q)
            IDLE: begin
                // Search starts just past the last owner so every requester gets a turn.
                for (int k = 1; k <= NUM_REQ; k++) begin
                    idx = (int'(rr_ptr_q) + k) % NUM_REQ;
                    if (!found && req_valid[idx]) begin
                        found   = 1'b1;
                        grant_d = GW'(idx);
                    end
                end
                if (found) begin
                    state_d = GRANT;
                    beat_d  = '0;
                end
            end
            GRANT: begin
                if (accept) begin
                    beat_d = beat_q + 8'd1;
                    if (beat_q + 8'd1 == BURST_LAST) begin
                        state_d  = IDLE;
                        rr_ptr_d = grant_q;
                    end
                end else if (!g_valid) begin
                    state_d  = IDLE;
                    rr_ptr_d = grant_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + TW'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + TW'(1) : rd_ptr_q;
        cnt_d      = cnt_q;
        rd_valid_d = '0;
        rd_data_d  = rd_data_q;
        tag_err_d  = tag_err_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
        if (rsp_valid) begin
            rd_data_d = rsp_data;
            if (pop) rd_valid_d = NUM_REQ'(1) << tag_mem_q[rd_ptr_q];
            else     tag_err_d  = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            beat_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            tag_err_q  <= 1'b0;
            rd_valid_q <= '0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_q     <= beat_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            tag_err_q  <= tag_err_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // Storage only; occupancy is tracked by cnt_q so no reset is needed.
    always_ff @(posedge clock) begin
        if (push) tag_mem_q[wr_ptr_q] <= grant_q;
    end

endmodule

// File: tb/tb_sdram_cmd_arbiter.sv
// Directed bench for sdram_cmd_arbiter: a queue-based reference model checked every
// cycle, plus literal expectations for burst timing, rotation, stalls and routing.
module tb_sdram_cmd_arbiter;

    localparam int NR = 2;
    localparam int MB = 8;
    localparam int TD = 8;

    logic                clock = 1'b0;
    logic                reset_n = 1'b0;
    logic [NR-1:0]       req_valid = '0;
    logic [NR-1:0]       req_wr_n = '0;
    logic [NR*25-1:0]    req_addr = '0;
    logic [NR*2-1:0]     req_be_n = '0;
    logic [NR*16-1:0]    req_data = '0;
    logic                efifo_full = 1'b0;
    logic                rsp_valid = 1'b0;
    logic [15:0]         rsp_data = '0;
    logic [NR-1:0]       req_ready, rd_valid;
    logic                efifo_wr, tag_err;
    logic [43:0]         efifo_wr_data;
    logic [15:0]         rd_data;

    sdram_cmd_arbiter #(.NUM_REQ(NR), .MAX_BURST(MB), .TAG_DEPTH(TD)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr_n(req_wr_n),
        .req_addr(req_addr), .req_be_n(req_be_n), .req_data(req_data),
        .efifo_wr(efifo_wr), .efifo_wr_data(efifo_wr_data), .efifo_full(efifo_full),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rd_valid(rd_valid), .rd_data(rd_data), .tag_err(tag_err)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: owner (-1 = none), rotation pointer, beats, outstanding-read owners.
    int             m_own = -1;
    int             m_rr = 0;
    int             m_beats = 0;
    int             m_tags[$];
    bit             m_err = 1'b0;
    logic [NR-1:0]  m_rdv = '0;
    logic [15:0]    m_rdd = '0;

    int             acc_log[$];
    logic [43:0]    word_log[$];
    logic [NR-1:0]  rdv_log[$];
    logic [15:0]    rdd_log[$];

    function automatic logic [43:0] pack(input int r);
        return {req_wr_n[r], req_addr[25*r +: 25], req_be_n[2*r +: 2], req_data[16*r +: 16]};
    endfunction

    always @(negedge clock) begin
        bit            acc;
        logic [NR-1:0] e_rdy;
        logic [43:0]   e_word;
        int            o;
        int            c;
        if (!reset_n) begin
            chk("rst_req_ready", req_ready, 0);
            chk("rst_efifo_wr", efifo_wr, 0);
            chk("rst_efifo_wr_data", efifo_wr_data, 0);
            chk("rst_rd_valid", rd_valid, 0);
            chk("rst_rd_data", rd_data, 0);
            chk("rst_tag_err", tag_err, 0);
            m_own = -1; m_rr = 0; m_beats = 0; m_tags.delete();
            m_err = 1'b0; m_rdv = '0; m_rdd = '0;
        end else begin
            acc    = (m_own >= 0) && req_valid[m_own] && !efifo_full
                     && !(req_wr_n[m_own] && m_tags.size() == TD);
            e_rdy  = acc ? (NR'(1) << m_own) : '0;
            e_word = acc ? pack(m_own) : '0;
            chk("req_ready", req_ready, e_rdy);
            chk("efifo_wr", efifo_wr, acc);
            chk("efifo_wr_data", efifo_wr_data, e_word);
            chk("rd_valid", rd_valid, m_rdv);
            if (m_rdv != '0) chk("rd_data", rd_data, m_rdd);
            chk("tag_err", tag_err, m_err);

            o = -1;
            for (int i = 0; i < NR; i++) if (req_ready[i]) o = i;
            acc_log.push_back(o);
            if (efifo_wr) word_log.push_back(efifo_wr_data);
            if (rd_valid != '0) begin
                rdv_log.push_back(rd_valid);
                rdd_log.push_back(rd_data);
            end

            if (rsp_valid) begin
                if (m_tags.size() > 0) begin
                    m_rdv = NR'(1) << m_tags.pop_front();
                    m_rdd = rsp_data;
                end else begin
                    m_rdv = '0;
                    m_err = 1'b1;
                end
            end else begin
                m_rdv = '0;
            end

            if (m_own < 0) begin
                for (int k = 1; k <= NR; k++) begin
                    c = (m_rr + k) % NR;
                    if (m_own < 0 && req_valid[c]) m_own = c;
                end
                m_beats = 0;
            end else if (acc) begin
                m_beats++;
                if (req_wr_n[m_own]) m_tags.push_back(m_own);
                if (m_beats == MB) begin
                    m_rr = m_own;
                    m_own = -1;
                end
            end else if (!req_valid[m_own]) begin
                m_rr = m_own;
                m_own = -1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic clear_logs();
        acc_log.delete(); word_log.delete(); rdv_log.delete(); rdd_log.delete();
    endtask

    function automatic int count_acc();
        int n = 0;
        foreach (acc_log[i]) if (acc_log[i] >= 0) n++;
        return n;
    endfunction

    // Present one command and hold it until it is accepted (valid is left high).
    task automatic issue(input int r, input logic wr, input logic [24:0] a,
                         input logic [15:0] d, input logic [1:0] be, output bit ok);
        ok = 1'b0;
        req_wr_n[r] = wr;
        req_addr[25*r +: 25] = a;
        req_be_n[2*r +: 2] = be;
        req_data[16*r +: 16] = d;
        req_valid[r] = 1'b1;
        for (int n = 0; n < 60; n++) begin
            @(negedge clock);
            if (req_ready[r]) begin
                @(posedge clock);
                #1;
                ok = 1'b1;
                return;
            end
            @(posedge clock);
            #1;
        end
        total++;
        bad++;
        $display("FAIL issue_timeout req=%0d actual=no_accept required=accept", r);
    endtask

    task automatic rsp_pulse(input logic [15:0] d);
        rsp_valid = 1'b1;
        rsp_data  = d;
        tick(1);
        rsp_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        int nmis;
        int e;
        int bp_exp[16];
        #1;
        chk("reset_req_ready", req_ready, 0);
        chk("reset_efifo_wr", efifo_wr, 0);
        chk("reset_rd_valid", rd_valid, 0);
        tick(2);
        reset_n = 1'b1;

        // Single requester, 3 writes.
        clear_logs();
        issue(0, 1'b0, 25'h100, 16'hA5A0, 2'b00, ok); chk("t1_ok0", ok, 1);
        issue(0, 1'b0, 25'h101, 16'hA5A1, 2'b00, ok); chk("t1_ok1", ok, 1);
        issue(0, 1'b0, 25'h102, 16'hA5A2, 2'b00, ok); chk("t1_ok2", ok, 1);
        req_valid[0] = 1'b0;
        tick(2);
        chk("t1_bubble", acc_log[0], -1);
        chk("t1_acc1", acc_log[1], 0);
        chk("t1_acc3", acc_log[3], 0);
        chk("t1_end", acc_log[4], -1);
        chk("t1_word0", word_log[0], {1'b0, 25'h100, 2'b00, 16'hA5A0});
        chk("t1_word2", word_log[2], {1'b0, 25'h102, 2'b00, 16'hA5A2});

        // Contention: both always valid; rr_ptr=0 so requester 1 goes first.
        clear_logs();
        req_wr_n = '0;
        req_data = {16'hBEEF, 16'hCAFE};
        req_valid = 2'b11;
        tick(40);
        req_valid = '0;
        nmis = 0;
        for (int i = 1; i <= 36; i++) begin
            int p;
            p = (i - 1) % 18;
            e = (p < 8) ? 1 : (p == 8) ? -1 : (p < 17) ? 0 : -1;
            if (acc_log[i] != e) nmis++;
        end
        chk("cont_first_owner", acc_log[1], 1);
        chk("cont_bubble", acc_log[9], -1);
        chk("cont_period_mismatches", nmis, 0);
        tick(2);

        // efifo_full for 5 cycles after 3 beats; burst resumes and still ends at 8 beats.
        clear_logs();
        bp_exp = '{-1, 0, 0, 0, -1, -1, -1, -1, -1, 0, 0, 0, 0, 0, -1, 0};
        req_valid[0] = 1'b1;
        tick(4);
        efifo_full = 1'b1;
        tick(5);
        efifo_full = 1'b0;
        tick(7);
        req_valid[0] = 1'b0;
        nmis = 0;
        for (int i = 0; i < 16; i++) if (acc_log[i] != bp_exp[i]) nmis++;
        chk("bp_pattern_mismatches", nmis, 0);
        chk("bp_stall_mid", acc_log[6], -1);
        tick(2);

        // Read routing.
        issue(1, 1'b1, 25'h00A, 16'h0, 2'b01, ok); req_valid[1] = 1'b0;
        issue(0, 1'b1, 25'h00B, 16'h0, 2'b10, ok); req_valid[0] = 1'b0;
        issue(1, 1'b1, 25'h00C, 16'h0, 2'b01, ok); req_valid[1] = 1'b0;
        tick(3);
        clear_logs();
        rsp_valid = 1'b1;
        rsp_data = 16'h1111; tick(1);
        rsp_data = 16'h2222; tick(1);
        rsp_data = 16'h3333; tick(1);
        rsp_valid = 1'b0;
        tick(2);
        chk("rr_count", rdv_log.size(), 3);
        chk("rr_v0", rdv_log[0], 2'b10);
        chk("rr_d0", rdd_log[0], 16'h1111);
        chk("rr_v1", rdv_log[1], 2'b01);
        chk("rr_d1", rdd_log[1], 16'h2222);
        chk("rr_v2", rdv_log[2], 2'b10);
        chk("rr_d2", rdd_log[2], 16'h3333);

        // Tag full: 8 reads fill it; the 9th stalls while a write still goes through.
        for (int k = 0; k < 8; k++) issue(0, 1'b1, 25'h200 + 25'(k), 16'h0, 2'b00, ok);
        req_addr[24:0] = 25'h208;
        clear_logs();
        tick(6);
        chk("tf_read_stall", count_acc(), 0);
        issue(0, 1'b0, 25'h300, 16'h7E57, 2'b00, ok);
        chk("tf_write_ok", ok, 1);
        req_wr_n[0] = 1'b1;
        req_addr[24:0] = 25'h208;
        clear_logs();
        tick(3);
        chk("tf_read_still_stalled", count_acc(), 0);
        req_valid[0] = 1'b0;
        rsp_pulse(16'h4444);
        issue(0, 1'b1, 25'h208, 16'h0, 2'b00, ok);
        chk("tf_read9_ok", ok, 1);
        req_valid[0] = 1'b0;
        for (int k = 0; k < 20; k++) begin
            rsp_pulse(16'h5000 + 16'(k));
            issue(k % 2, 1'b1, 25'h400 + 25'(k), 16'h0, 2'b00, ok);
            req_valid[k % 2] = 1'b0;
        end
        tick(2);
        clear_logs();
        for (int j = 0; j < 8; j++) rsp_pulse(16'h6000 + 16'(j));
        tick(2);
        chk("wrap_count", rdv_log.size(), 8);
        nmis = 0;
        for (int j = 0; j < 8; j++) begin
            if (rdv_log[j] != ((j % 2 == 0) ? 2'b01 : 2'b10)) nmis++;
            if (rdd_log[j] != 16'h6000 + 16'(j)) nmis++;
        end
        chk("wrap_route_mismatches", nmis, 0);

        // Response with empty tag FIFO.
        rsp_pulse(16'h7777);
        @(negedge clock);
        chk("err_tag_err", tag_err, 1);
        chk("err_rd_valid", rd_valid, 0);
        @(posedge clock);
        #1;

        // Asynchronous reset mid-burst.
        issue(0, 1'b0, 25'h500, 16'h0001, 2'b00, ok);
        issue(0, 1'b0, 25'h501, 16'h0002, 2'b00, ok);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_req_ready", req_ready, 0);
        chk("ar_efifo_wr", efifo_wr, 0);
        chk("ar_efifo_wr_data", efifo_wr_data, 0);
        chk("ar_rd_data", rd_data, 0);
        chk("ar_tag_err", tag_err, 0);
        tick(2);
        reset_n = 1'b1;
        clear_logs();
        tick(3);
        chk("ar_first_bubble", acc_log[0], -1);
        chk("ar_first_accept", acc_log[1], 0);
        req_valid[0] = 1'b0;
        tick(2);
        rsp_pulse(16'h8888);
        @(negedge clock);
        chk("ar_post_tag_err", tag_err, 1);
        chk("ar_post_rd_valid", rd_valid, 0);
        @(posedge clock);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
